// File: rtl/servo_cmd_sequencer.sv
// servo_cmd_sequencer: debounces the servo push-button and ramps the commanded pulse width
// toward the selected endpoint, strobing LoadModN one clock after each frame tick with news.
module servo_cmd_sequencer #(
    parameter logic [31:0] FrameCycles    = 32'd1000000,
    parameter logic [31:0] DebounceCycles = 32'd500000,
    parameter logic [31:0] MinWidth       = 32'd500000,
    parameter logic [31:0] MaxWidth       = 32'd2500000,
    parameter logic [31:0] StepWidth      = 32'd100000
) (
    input  logic        ClockIn,
    input  logic        Reset,
    input  logic        BtnRaw,
    output logic        BtnState,
    output logic        LoadModN,
    output logic [31:0] PulseWidth,
    output logic        Moving
);
    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} dbState_t;
    dbState_t state, stateNext;
    logic syncMeta, btnSync, btnNext, frameTick, pending, pwChange, btnChange, loadEvent, rising;
    logic [31:0] dbCount, dbCountNext, frameCount, target, gap, step, pwNext;
    always_comb begin
        stateNext = state;
        dbCountNext = dbCount;
        btnNext = BtnState;
        case (state)
            S_LOW: begin
                if (btnSync) begin
                    stateNext = S_RISE;
                    dbCountNext = '0;
                end
            end
            S_RISE: begin
                if (!btnSync) stateNext = S_LOW;
                else begin
                    dbCountNext = dbCount + 32'd1;
                    if (dbCount == DebounceCycles - 32'd1) begin
                        stateNext = S_HIGH;
                        btnNext = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (!btnSync) begin
                    stateNext = S_FALL;
                    dbCountNext = '0;
                end
            end
            default: begin
                if (btnSync) stateNext = S_HIGH;
                else begin
                    dbCountNext = dbCount + 32'd1;
                    if (dbCount == DebounceCycles - 32'd1) begin
                        stateNext = S_LOW;
                        btnNext = 1'b0;
                    end
                end
            end
        endcase
    end
    // The gap is taken in the correct direction first so the step is clamped without wrap.
    always_comb begin
        target = BtnState ? MinWidth : MaxWidth;
        rising = PulseWidth < target;
        gap = rising ? target - PulseWidth : PulseWidth - target;
        step = gap < StepWidth ? gap : StepWidth;
        pwNext = rising ? PulseWidth + step : PulseWidth - step;
        frameTick = frameCount == FrameCycles - 32'd1;
        pwChange = frameTick && (PulseWidth != target);
        btnChange = btnNext != BtnState;
        loadEvent = pending || pwChange || btnChange;
    end
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            syncMeta <= 1'b0;
            btnSync <= 1'b0;
            state <= S_LOW;
            dbCount <= '0;
            BtnState <= 1'b0;
            frameCount <= '0;
            PulseWidth <= MaxWidth;
            LoadModN <= 1'b0;
            pending <= 1'b0;
            Moving <= 1'b0;
        end else begin
            syncMeta <= BtnRaw;
            btnSync <= syncMeta;
            state <= stateNext;
            dbCount <= dbCountNext;
            BtnState <= btnNext;
            frameCount <= frameTick ? '0 : frameCount + 32'd1;
            if (frameTick) PulseWidth <= pwNext;
            LoadModN <= frameTick && loadEvent;
            pending <= !frameTick && loadEvent;
            Moving <= PulseWidth != target;
        end
    end
endmodule

// File: doc/servo_cmd_sequencer.md
# servo_cmd_sequencer

Upstream command stage for the servo PWM generator. Synchronizes and debounces the raw push-button and ramps a commanded pulse width toward the endpoint selected by the debounced level. It issues a one-cycle load strobe, aligned to an internal 20 ms frame, whenever the command changes. Its BtnState/LoadModN outputs drive the PWM generator directly; PulseWidth feeds width-programmable PWM variants.

## Interface
- FrameCycles, 32'd1000000, clocks per servo frame (20 ms at 50 MHz); must be ≥ 2
- DebounceCycles, 32'd500000, clocks the synchronized button must hold a new level before it is accepted; must be ≥ 1
- MinWidth, 32'd500000, PulseWidth endpoint when BtnState=1 (0°)
- MaxWidth, 32'd2500000, PulseWidth endpoint when BtnState=0 (180°); MaxWidth > MinWidth
- StepWidth, 32'd100000, maximum PulseWidth change per frame; must be ≥ 1
- ClockIn  input  1  sole clock, rising edge
- Reset  input  1  synchronous, active-high reset
- BtnRaw  input  1  asynchronous raw button level
- BtnState  output  1  debounced button level
- LoadModN  output  1  one-cycle load strobe to the PWM stage
- PulseWidth  output  32  commanded pulse width, unsigned
- Moving  output  1  high while PulseWidth ≠ target

## Operation
- Synchronizer: two flops, BtnRaw → BtnSync. The debouncer sees only BtnSync.
- Debounce FSM states: S_LOW, S_RISE, S_HIGH, S_FALL. Counter DbCount is 32 bits.
  - S_LOW: if BtnSync=1, go to S_RISE and set DbCount=0.
  - S_RISE: if BtnSync=0, go to S_LOW. Otherwise increment DbCount. When DbCount=DebounceCycles-1, go to S_HIGH and set BtnState=1.
  - S_HIGH / S_FALL: mirror image of the above. S_FALL exits to S_LOW with BtnState=0.
  - A glitch shorter than DebounceCycles never changes BtnState.
- Target is combinational: Target = BtnState ? MinWidth : MaxWidth.
- Frame counter FrameCount runs 0..FrameCycles-1 and wraps. FrameTick is asserted when FrameCount = FrameCycles-1.
- Ramp, on FrameTick only:
  - If PulseWidth < Target: PulseWidth += min(StepWidth, Target-PulseWidth).
  - If PulseWidth > Target: PulseWidth -= min(StepWidth, PulseWidth-Target).
  - Compute the difference before comparing with StepWidth. No overflow or underflow is permitted, and PulseWidth never overshoots Target.
- Pending flag:
  - Set on any BtnState change.
  - Set on any PulseWidth update.
- Load:
  - On FrameTick with Pending=1, or with a Pending-setting event in that same cycle, LoadModN=1 on the next cycle. Pending clears in the same cycle LoadModN is asserted.
  - An event coinciding with the LoadModN cycle re-sets Pending and is reported on the next frame.
  - LoadModN is never asserted on two consecutive cycles.
- Moving = (PulseWidth ≠ Target), registered.

## Timing
- Reset values: BtnState=0, LoadModN=0, PulseWidth=MaxWidth, Moving=0, FSM=S_LOW, DbCount=0, FrameCount=0, Pending=0, synchronizer flops=0.
- Reset asserted mid-debounce or mid-ramp: all state returns to the reset values at the next edge, with no LoadModN on the reset-release cycle.
- Debounce latency: BtnRaw held stable from edge N changes BtnState at edge N+2+DebounceCycles. That is 2 synchronizer clocks plus DebounceCycles clocks of qualification.
- PulseWidth updates on the edge that samples FrameTick. LoadModN follows exactly 1 clock later, so BtnState and PulseWidth are stable while LoadModN=1.
- Moving updates 1 clock after BtnState or PulseWidth changes.
- Ramp duration is ceil((MaxWidth-MinWidth)/StepWidth) frames.
- BtnState reversing mid-ramp redirects the ramp at the next FrameTick, starting from the current PulseWidth.

## Test plan
- Reset: hold Reset 3 cycles with BtnRaw=1 → BtnState=0, LoadModN=0, PulseWidth=2500000, Moving=0 throughout.
- Debounce (DebounceCycles=4): BtnRaw high pulse of 3 clocks → BtnState stays 0. BtnRaw held high from edge N → BtnState=1 at edge N+6.
- Full ramp (FrameCycles=16, StepWidth=100000, BtnRaw held 1) → PulseWidth steps 2400000…500000, one step per frame over 20 frames. LoadModN fires once per step, 1 clock after FrameTick. Moving drops after the final step, and no further LoadModN occurs.
- Clamp (StepWidth=300000) → PulseWidth sequence 2200000, 1900000, 1600000, 1300000, 1000000, 700000, 500000, then no change.
- Reversal: release the button after PulseWidth reaches 1600000 → at the next FrameTick PulseWidth=1700000, then ramps up to 2500000.
- Mid-operation reset: assert Reset during S_RISE and during a ramp → all outputs take reset values on the next edge, and a fresh debounce is required.
